multicycle_datapath: RTL and testbench
======================================

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/register/address width; legal range 32..64.
REQ-002 SHALL have parameter NREG, default 16, register count including R15 = PC; fixed at 16 in this generation.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_req  out  1  memory request, fetch or data.
REQ-006 SHALL have port mem_we  out  1  1 = store, 0 = read.
REQ-007 SHALL have port mem_addr  out  WIDTH  byte address.
REQ-008 SHALL have port mem_wdata  out  WIDTH  store data.
REQ-009 SHALL have port mem_rdata  in  WIDTH  read data; instruction in bits [31:0].
REQ-010 SHALL have port mem_ack  in  1  request complete; read data valid same cycle.
REQ-011 SHALL have port pc  out  WIDTH  current PC.
REQ-012 SHALL have port alu_flags  out  4  {C,V,N,Z}, bits 3..0.
REQ-013 SHALL have port halted  out  1  high in HALT state.

Function
REQ-014 SHALL use FSM states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack latch IR and set pc<=pc+4, then go to DECODE; otherwise hold.
REQ-016 DECODE: latch A=reg[Rn], B=reg[Rm or Rd for STR]; R15 reads as pc+4, i.e. fetch address +8.
REQ-017 DECODE: cond=1111 goes to HALT; cond 1110 (AL) executes; 0000 executes if Z=1; 0001 executes if Z=0; any other cond value, or a failed condition, returns to FETCH.
REQ-018 EXECUTE, DP (IR[27:26]=00): SrcB = zero-extended imm8 if IR[25]=1, else B; cmd IR[24:21] is 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other cmd executes as ADD. Latch ALUOut, then go to WRITEBACK.
REQ-019 Flags: updated only in DP EXECUTE with IR[20]=1. N = MSB and Z = (result==0) for all ops; C and V from the WIDTH-bit add/sub, where SUB C = no borrow; AND/ORR clear C and V.
REQ-020 EXECUTE, MEM (IR[27:26]=01): ALUOut = A + zero-extended imm12, then go to MEMORY.
REQ-021 EXECUTE, BRANCH (IR[27:26]=10): pc <= pc + 4 + (sign-extended imm24 << 2), then go to FETCH; IR[27:26]=11 is treated as a failed condition.
REQ-022 MEMORY: mem_req=1, mem_addr=ALUOut, mem_we=~IR[20], mem_wdata=B; hold until mem_ack. On ack: LDR latches mem_rdata and goes to WRITEBACK; STR goes to FETCH.
REQ-023 WRITEBACK: reg[Rd] <= ALUOut (DP) or load data (LDR); Rd=15 writes pc instead; then go to FETCH.
REQ-024 Handshake: mem_addr, mem_we and mem_wdata SHALL be stable while mem_req=1 and mem_ack=0; mem_ack with mem_req=0 is ignored; mem_req drops the cycle after ack.
REQ-025 Zero-wait latency (ack in the request cycle): DP 4 cycles, LDR 5, STR 4, B 3, condition-fail 2.
REQ-026 HALT: mem_req=0, halted=1; the block stays in HALT until reset.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; pc wraps from 2^WIDTH-4 to 0.

Reset
REQ-028 While reset=0 (asynchronous): state=FETCH, pc=0, all registers 0, IR=0, flags 0; mem_req, mem_we and halted are 0; mem_addr and mem_wdata are 0.
REQ-029 The first fetch from address 0 SHALL be requested in the first clk edge cycle after reset rises.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately: mem_req drops asynchronously and no register or memory write completes.

Verification
REQ-031 ADD R1,R0,#5 (0xE2801005) then ADDS R2,R1,#0xFB, zero-wait -> R1=5, R2=0x100, flags 0000, 8 cycles total.
REQ-032 SUBS R3,R1,R1 then BEQ +2 -> Z=1, branch taken, next fetch at the branch address +16; repeat with BNE -> 2-cycle skip.
REQ-033 STR R1,[R0,#0x40] then LDR R4,[R0,#0x40], with mem_ack delayed 3 cycles -> addr/wdata held stable, R4=5, LDR takes 8 cycles.
REQ-034 0xFFFFFFFF at address 0x10 -> halted=1 after DECODE; mem_req stays 0 for 20 cycles.
REQ-035 Reset pulled low during MEMORY of a store -> mem_req=0 asynchronously, pc=0, no write observed, fetch from 0 restarts.
REQ-036 WIDTH=64: ADDS of 0xFFFF_FFFF_FFFF_FFFF+1 -> result 0, Z=1, C=1, V=0.

Source files
------------

// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if: single-port memory request/acknowledge bus
interface multicycle_datapath_if #(parameter int WIDTH = 32);
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;
   modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
   modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK core, R15 aliases pc
module multicycle_datapath #(
   parameter int WIDTH = 32,
   parameter int NREG  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_datapath_if.master mem,
   output logic [WIDTH-1:0]      pc,
   output logic [3:0]            alu_flags,
   output logic                  halted
);
   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT} state_t;
   state_t state, nxt;
   logic [WIDTH-1:0] rf [NREG];
   logic [31:0] ir;
   logic [WIDTH-1:0] a, b, alu_out, mdr;
   logic [WIDTH-1:0] pc4, pc_n, rd_a, rd_b, src_b, bb, sum, res, ea, off, wb_data;
   logic [WIDTH:0] sum_x;
   logic [3:0] cond, cmd, rn, rd, idx_b, flags_n;
   logic [1:0] op;
   logic sub, logic_op, take, fetch_ack;
   always_comb begin
      cond = ir[31:28];
      op = ir[27:26];
      cmd = ir[24:21];
      rn = ir[19:16];
      rd = ir[15:12];
      idx_b = (op == 2'b01 && !ir[20]) ? rd : ir[3:0];
      pc4 = pc + WIDTH'(4);
      rd_a = rn == 4'hF ? pc4 : rf[rn];
      rd_b = idx_b == 4'hF ? pc4 : rf[idx_b];
      src_b = ir[25] ? {{(WIDTH-8){1'b0}}, ir[7:0]} : b;
      sub = cmd == 4'b0010;
      bb = sub ? ~src_b : src_b;
      sum_x = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
      sum = sum_x[WIDTH-1:0];
      logic_op = cmd == 4'b0000 || cmd == 4'b1100;
      res = cmd == 4'b0000 ? a & src_b : cmd == 4'b1100 ? a | src_b : sum;
      flags_n = {logic_op ? 2'b00 : {sum_x[WIDTH], a[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]},
                 res[WIDTH-1], res == '0};
      ea = a + {{(WIDTH-12){1'b0}}, ir[11:0]};
      off = {{(WIDTH-26){ir[23]}}, ir[23:0], 2'b00};
      wb_data = op == 2'b01 ? mdr : alu_out;
      take = op != 2'b11 && (cond == 4'hE || (cond == 4'h0 && alu_flags[0]) || (cond == 4'h1 && !alu_flags[0]));
      fetch_ack = state == FETCH && mem.mem_req && mem.mem_ack;
      nxt = state == FETCH ? (fetch_ack ? DECODE : FETCH) :
            state == DECODE ? (cond == 4'hF ? HALT : take ? EXECUTE : FETCH) :
            state == EXECUTE ? (op == 2'b00 ? WRITEBACK : op == 2'b01 ? MEMORY : FETCH) :
            state == MEMORY ? (!mem.mem_ack ? MEMORY : ir[20] ? WRITEBACK : FETCH) :
            state == WRITEBACK ? FETCH : HALT;
      // pc already points past the fetched word, so branches and R15 reads add another 4
      pc_n = fetch_ack ? pc4 :
             (state == EXECUTE && op == 2'b10) ? pc4 + off :
             (state == WRITEBACK && rd == 4'hF) ? wb_data : pc;
   end
   // bus outputs are registered from the next state so a request is live in its first cycle
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= FETCH;
         pc <= '0;
         ir <= '0;
         a <= '0;
         b <= '0;
         alu_out <= '0;
         mdr <= '0;
         alu_flags <= '0;
         halted <= 1'b0;
         mem.mem_req <= 1'b0;
         mem.mem_we <= 1'b0;
         mem.mem_addr <= '0;
         mem.mem_wdata <= '0;
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         state <= nxt;
         pc <= pc_n;
         halted <= nxt == HALT;
         mem.mem_req <= nxt == FETCH || nxt == MEMORY;
         mem.mem_we <= nxt == MEMORY && !ir[20];
         if (nxt == FETCH) mem.mem_addr <= pc_n;
         else if (nxt == MEMORY) begin
            mem.mem_addr <= ea;
            mem.mem_wdata <= b;
         end
         if (fetch_ack) ir <= mem.mem_rdata[31:0];
         if (state == DECODE) begin
            a <= rd_a;
            b <= rd_b;
         end
         if (state == EXECUTE) alu_out <= op == 2'b01 ? ea : res;
         if (state == EXECUTE && op == 2'b00 && ir[20]) alu_flags <= flags_n;
         if (state == MEMORY && mem.mem_ack) mdr <= mem.mem_rdata;
         if (state == WRITEBACK && rd != 4'hF) rf[rd] <= wb_data;
      end
endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed programs on a 32-bit core with a delayable memory, plus a 64-bit core
module tb_multicycle_datapath;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [31:0] pc;
   logic [3:0] flags;
   logic halted;
   logic [63:0] pc64;
   logic [3:0] flags64;
   logic halted64;
   logic [31:0] imem [16];
   logic [31:0] dmem [64];
   int dly = 0, wcnt = 0, cyc = 0, lcnt = 0;
   int log_cyc [64];
   logic [31:0] log_addr [64];
   logic [31:0] log_wd [64];
   logic log_we [64];
   int n_chk = 0, n_fail = 0, base = 0;
   multicycle_datapath_if #(.WIDTH(32)) m ();
   multicycle_datapath_if #(.WIDTH(64)) m64 ();
   multicycle_datapath #(.WIDTH(32), .NREG(16)) dut (.clk(clk), .reset(reset), .mem(m), .pc(pc), .alu_flags(flags), .halted(halted));
   multicycle_datapath #(.WIDTH(64), .NREG(16)) dut64 (.clk(clk), .reset(reset), .mem(m64), .pc(pc64), .alu_flags(flags64), .halted(halted64));
   always #5 clk = ~clk;
   assign m.mem_rdata = m.mem_addr < 32'h40 ? imem[m.mem_addr[5:2]] :
                        m.mem_addr == 32'h80 ? 32'h7FFFFFFF : dmem[m.mem_addr[7:2]];
   assign m.mem_ack = m.mem_req && (m.mem_addr < 32'h40 || wcnt >= dly);
   assign m64.mem_ack = m64.mem_req;
   assign m64.mem_rdata = {32'h0, m64.mem_addr == 64'h0 ? 32'hE2501001 :
                                  m64.mem_addr == 64'h4 ? 32'hE2912001 : 32'hFFFFFFFF};
   always @(posedge clk) begin
      cyc <= cyc + 1;
      wcnt <= (m.mem_req && !m.mem_ack) ? wcnt + 1 : 0;
      if (m.mem_req && m.mem_ack) begin
         if (m.mem_we) dmem[m.mem_addr[7:2]] <= m.mem_wdata;
         log_cyc[lcnt[5:0]] <= cyc;
         log_addr[lcnt[5:0]] <= m.mem_addr;
         log_we[lcnt[5:0]] <= m.mem_we;
         log_wd[lcnt[5:0]] <= m.mem_wdata;
         lcnt <= lcnt + 1;
      end
   end
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask
   task automatic wait_log(input int n);
      for (int t = 0; t < 300 && lcnt < n; t++) @(negedge clk);
      check("log_wait", 64'(lcnt >= n), 64'd1);
   endtask
   task automatic wait_halt();
      for (int t = 0; t < 300 && !halted; t++) @(negedge clk);
      check("halt_wait", 64'(halted), 64'd1);
   endtask
   task automatic idle_check(input string tag);
      int hi = 0;
      repeat (20) begin
         @(negedge clk);
         hi += int'(m.mem_req);
      end
      check(tag, 64'(hi), 64'd0);
   endtask
   initial begin
      #1 reset = 1'b0;
      for (int i = 0; i < 16; i++) imem[i] = 32'hFFFFFFFF;
      imem[0] = 32'hE2801005;
      imem[1] = 32'hE29120FB;
      imem[2] = 32'hE0513001;
      imem[3] = 32'h0A000002;
      imem[7] = 32'h1A000002;
      imem[8] = 32'hE5801040;
      imem[9] = 32'hE5904040;
      dly = 3;
      repeat (2) @(negedge clk);
      check("rst_req", m.mem_req, 0);
      check("rst_we", m.mem_we, 0);
      check("rst_addr", m.mem_addr, 0);
      check("rst_wdata", m.mem_wdata, 0);
      check("rst_pc", pc, 0);
      check("rst_flags", flags, 0);
      check("rst_halted", halted, 0);
      base = lcnt;
      reset = 1'b1;
      @(negedge clk);
      check("first_req", m.mem_req, 1);
      check("first_addr", m.mem_addr, 0);
      wait_log(base + 3);
      check("add_cycles", 64'(log_cyc[base+1] - log_cyc[base]), 4);
      check("adds_total", 64'(log_cyc[base+2] - log_cyc[base]), 8);
      check("r1", dut.rf[1], 5);
      check("r2", dut.rf[2], 32'h100);
      check("adds_flags", flags, 4'b0000);
      wait_log(base + 6);
      check("beq_target", log_addr[base+4], 32'h1C);
      check("beq_cycles", 64'(log_cyc[base+4] - log_cyc[base+3]), 3);
      check("bne_addr", log_addr[base+5], 32'h20);
      check("bne_cycles", 64'(log_cyc[base+5] - log_cyc[base+4]), 2);
      check("subs_flags", flags, 4'b1001);
      check("r3", dut.rf[3], 0);
      for (int t = 0; t < 50 && !(m.mem_req && m.mem_we); t++) @(negedge clk);
      check("str_req", 64'(m.mem_req && m.mem_we), 1);
      for (int k = 0; k < 4; k++) begin
         check("str_addr_hold", m.mem_addr, 32'h40);
         check("str_wdata_hold", m.mem_wdata, 5);
         check("str_req_hold", m.mem_req, 1);
         @(negedge clk);
      end
      wait_log(base + 10);
      check("str_we", log_we[base+6], 1);
      check("str_addr", log_addr[base+6], 32'h40);
      check("str_data", log_wd[base+6], 5);
      check("str_ack_delay", 64'(log_cyc[base+6] - log_cyc[base+5]), 6);
      check("ldr_we", log_we[base+8], 0);
      check("ldr_cycles", 64'(log_cyc[base+9] - log_cyc[base+7]), 8);
      check("halt_fetch", log_addr[base+9], 32'h28);
      check("mem40", dmem[16], 5);
      check("r4", dut.rf[4], 5);
      check("halt_early", halted, 0);
      @(negedge clk);
      check("halted", halted, 1);
      check("halt_pc", pc, 32'h2C);
      idle_check("halt_idle_a");
      check("halt_stays", halted, 1);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) imem[i] = 32'hFFFFFFFF;
      imem[0] = 32'hE2801007;
      imem[1] = 32'hE5801040;
      imem[2] = 32'hE2811001;
      imem[3] = 32'hE2811001;
      dly = 50;
      @(negedge clk);
      reset = 1'b1;
      for (int t = 0; t < 100 && !(m.mem_req && m.mem_we); t++) @(negedge clk);
      check("abort_str_req", 64'(m.mem_req && m.mem_we), 1);
      #2 reset = 1'b0;
      #1;
      check("abort_req", m.mem_req, 0);
      check("abort_we", m.mem_we, 0);
      check("abort_addr", m.mem_addr, 0);
      check("abort_pc", pc, 0);
      check("abort_r1", dut.rf[1], 0);
      dly = 0;
      @(negedge clk);
      check("abort_nowrite", dmem[16], 5);
      base = lcnt;
      reset = 1'b1;
      @(negedge clk);
      check("restart_req", m.mem_req, 1);
      check("restart_addr", m.mem_addr, 0);
      wait_log(base + 1);
      check("restart_log", log_addr[base], 0);
      wait_halt();
      check("c_mem40", dmem[16], 7);
      check("c_r1", dut.rf[1], 9);
      check("c_pc", pc, 32'h14);
      idle_check("halt_idle_c");
      reset = 1'b0;
      for (int i = 0; i < 16; i++) imem[i] = 32'hFFFFFFFF;
      imem[0] = 32'hE2502001;
      imem[1] = 32'hE21230F0;
      imem[2] = 32'hE1934002;
      imem[3] = 32'hE0925002;
      imem[4] = 32'hE5906080;
      imem[5] = 32'hE2967001;
      imem[6] = 32'hE28F8000;
      imem[7] = 32'hE3A29003;
      imem[8] = 32'hEC000000;
      imem[9] = 32'hE280F038;
      @(negedge clk);
      base = lcnt;
      reset = 1'b1;
      wait_log(base + 2);
      check("subs_neg_flags", flags, 4'b0010);
      wait_log(base + 3);
      check("ands_flags", flags, 4'b0000);
      wait_log(base + 4);
      check("orrs_flags", flags, 4'b0010);
      wait_log(base + 5);
      check("adds_carry_flags", flags, 4'b1010);
      wait_log(base + 8);
      check("adds_ovf_flags", flags, 4'b0110);
      check("ldr_zero_wait", 64'(log_cyc[base+6] - log_cyc[base+4]), 5);
      wait_log(base + 12);
      check("op11_cycles", 64'(log_cyc[base+10] - log_cyc[base+9]), 2);
      check("r15_wb_addr", log_addr[base+11], 32'h38);
      check("r15_wb_cycles", 64'(log_cyc[base+11] - log_cyc[base+10]), 4);
      wait_halt();
      check("b_r2", dut.rf[2], 32'hFFFFFFFF);
      check("b_r3", dut.rf[3], 32'hF0);
      check("b_r4", dut.rf[4], 32'hFFFFFFFF);
      check("b_r5", dut.rf[5], 32'hFFFFFFFE);
      check("b_r6", dut.rf[6], 32'h7FFFFFFF);
      check("b_r7", dut.rf[7], 32'h80000000);
      check("b_r8_pc_read", dut.rf[8], 32'h20);
      check("b_r9_default_add", dut.rf[9], 2);
      check("b_pc", pc, 32'h3C);
      check("w64_halted", halted64, 1);
      check("w64_pc", pc64, 64'hC);
      check("w64_flags", flags64, 4'b1001);
      check("w64_r1", dut64.rf[1], 64'hFFFFFFFFFFFFFFFF);
      check("w64_r2", dut64.rf[2], 0);
      check("w64_req", m64.mem_req, 0);
      check("w64_we", m64.mem_we, 0);
      check("w64_wdata", m64.mem_wdata, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
